gwa_input_cond: RTL and testbench

- Input-conditioning stage directly upstream of the drink-vending FSM.
- Takes raw, asynchronous, bouncy coin-sensor and selection-key lines.
- Per channel: 2-flop synchroniser, debounce, then rising-edge detection.
- Issues clean single-cycle pulses EU1 / EU2 / WT to the FSM. At most one pulse per cycle; simultaneous coins are never lost.

---
 rtl/gwa_pkg.sv | 18 +
 rtl/gwa_debounce.sv | 57 +++++
 rtl/gwa_input_cond.sv | 96 +++++++++
 tb/tb_gwa_input_cond.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/gwa_pkg.sv
// Shared constants for the gwa input-conditioning stage.
// The optional credit counter in gwa_input_cond is enabled by defining GWA_INCNT_EN.
package gwa_pkg;

  localparam int NUM_CH         = 3;
  localparam int CH_EU1         = 0;
  localparam int CH_EU2         = 1;
  localparam int CH_WT          = 2;

  localparam int VAL_EU1        = 1;
  localparam int VAL_EU2        = 2;

  localparam int CREDIT_W       = 8;
  localparam int DEB_CYCLES_DEF = 4;

  typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/gwa_debounce.sv
// One input channel: 2-flop synchroniser, debounce counter with stable level,
// and a strobe on the edge where the stable level goes 0 -> 1.
module gwa_debounce
  import gwa_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  generate
    if (DEB_CYCLES < 2) begin : g_bad_param
      $error("gwa_debounce: DEB_CYCLES must be >= 2");
    end
  endgenerate

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_done;

  assign w_diff = (r_sync2 != r_level);
  assign w_done = w_diff && (r_cnt == CNT_MAX);

  // Strobe is asserted in the cycle whose edge moves the level high, so the
  // caller can latch its pending flag on that same edge.
  assign rise = w_done & r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done) begin
        r_level <= r_sync2;
      end
    end
  end

endmodule

// File: rtl/gwa_input_cond.sv
// Conditions the raw coin/key lines into single-cycle EU1/EU2/WT pulses with
// a fixed-priority arbiter. Define GWA_INCNT_EN to add the saturating CREDIT output.
module gwa_input_cond
  import gwa_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic EU1_RAW,
  input  logic EU2_RAW,
  input  logic WT_RAW,
  output logic EU1,
  output logic EU2,
  output logic WT
`ifdef GWA_INCNT_EN
  ,
  output logic [CREDIT_W-1:0] CREDIT
`endif
);

  ch_vec_t w_raw;
  ch_vec_t w_rise;
  ch_vec_t w_grant;
  ch_vec_t r_pend;
  ch_vec_t r_out;

  assign w_raw[CH_EU1] = EU1_RAW;
  assign w_raw[CH_EU2] = EU2_RAW;
  assign w_raw[CH_WT]  = WT_RAW;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      gwa_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .raw  (w_raw[gi]),
        .rise (w_rise[gi])
      );
    end
  endgenerate

  // Lowest channel index wins; only already-latched events compete.
  always_comb begin
    w_grant         = '0;
    w_grant[CH_EU1] = r_pend[CH_EU1];
    w_grant[CH_EU2] = r_pend[CH_EU2] & ~r_pend[CH_EU1];
    w_grant[CH_WT]  = r_pend[CH_WT] & ~r_pend[CH_EU2] & ~r_pend[CH_EU1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_out  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_grant) | w_rise;
      r_out  <= w_grant;
    end
  end

  assign EU1 = r_out[CH_EU1];
  assign EU2 = r_out[CH_EU2];
  assign WT  = r_out[CH_WT];

`ifdef GWA_INCNT_EN
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W:0]   w_add;
  logic [CREDIT_W:0]   w_sum;

  always_comb begin
    w_add = '0;
    if (w_grant[CH_EU1]) begin
      w_add = (CREDIT_W+1)'(VAL_EU1);
    end else if (w_grant[CH_EU2]) begin
      w_add = (CREDIT_W+1)'(VAL_EU2);
    end
    w_sum = {1'b0, r_credit} + w_add;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credit <= '0;
    end else if (w_sum[CREDIT_W]) begin
      r_credit <= '1;
    end else begin
      r_credit <= w_sum[CREDIT_W-1:0];
    end
  end

  assign CREDIT = r_credit;
`endif

endmodule

// File: tb/tb_gwa_input_cond.sv
// Directed bench for gwa_input_cond: reset hold, clean coin, bounce, contention,
// long key hold and reset while events are pending.
module tb_gwa_input_cond;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic EU1_RAW = 1'b0;
  logic EU2_RAW = 1'b0;
  logic WT_RAW = 1'b0;
  logic EU1, EU2, WT;
`ifdef GWA_INCNT_EN
  logic [7:0] CREDIT;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int c1, c2, c3, multi;
  int t1, t2, t3;
  int base;

  always #5 clk = ~clk;

  gwa_input_cond #(.DEB_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .EU1_RAW (EU1_RAW),
    .EU2_RAW (EU2_RAW),
    .WT_RAW  (WT_RAW),
    .EU1     (EU1),
    .EU2     (EU2),
    .WT      (WT)
`ifdef GWA_INCNT_EN
    ,
    .CREDIT  (CREDIT)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic clr();
    c1 = 0; c2 = 0; c3 = 0;
    t1 = -1; t2 = -1; t3 = -1;
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (EU1) begin c1++; t1 = cyc; end
      if (EU2) begin c2++; t2 = cyc; end
      if (WT)  begin c3++; t3 = cyc; end
      if ((int'(EU1) + int'(EU2) + int'(WT)) > 1) multi++;
    end
  endtask

  initial begin
    multi = 0;
    clr();

    // Reset with all lines high, then release with lines still high.
    EU1_RAW = 1'b1; EU2_RAW = 1'b1; WT_RAW = 1'b1;
    tick(3);
    chk("rst_eu1", int'(EU1), 0);
    chk("rst_eu2", int'(EU2), 0);
    chk("rst_wt",  int'(WT), 0);
    rst = 1'b1;
    tick(20);
    chk("hold_pulses", c1 + c2 + c3, 0);
`ifdef GWA_INCNT_EN
    chk("hold_credit", int'(CREDIT), 0);
`endif
    EU1_RAW = 1'b0; EU2_RAW = 1'b0; WT_RAW = 1'b0;
    tick(20);
    chk("fall_pulses", c1 + c2 + c3, 0);

    // Clean 1-euro coin: pulse visible after edge 7.
    clr();
    EU1_RAW = 1'b1; base = cyc;
    tick(8);
    EU1_RAW = 1'b0;
    tick(15);
    chk("clean_cnt", c1, 1);
    chk("clean_lat", t1 - base, 7);
    chk("clean_other", c2 + c3, 0);
`ifdef GWA_INCNT_EN
    chk("clean_credit", int'(CREDIT), 1);
`endif

    // Bouncing 2-euro line is rejected, then a clean 6-cycle press is accepted.
    clr();
    EU2_RAW = 1'b1; tick(2);
    EU2_RAW = 1'b0; tick(2);
    EU2_RAW = 1'b1; tick(2);
    EU2_RAW = 1'b0; tick(15);
    chk("bounce_cnt", c2, 0);
    EU2_RAW = 1'b1; base = cyc;
    tick(6);
    EU2_RAW = 1'b0;
    tick(15);
    chk("eu2_cnt", c2, 1);
    chk("eu2_lat", t2 - base, 7);
`ifdef GWA_INCNT_EN
    chk("eu2_credit", int'(CREDIT), 3);
`endif

    // All three rise together: served in priority order on consecutive cycles.
    clr();
    EU1_RAW = 1'b1; EU2_RAW = 1'b1; WT_RAW = 1'b1; base = cyc;
    tick(10);
    EU1_RAW = 1'b0; EU2_RAW = 1'b0; WT_RAW = 1'b0;
    tick(20);
    chk("sim_cnt1", c1, 1);
    chk("sim_cnt2", c2, 1);
    chk("sim_cnt3", c3, 1);
    chk("sim_t1", t1 - base, 7);
    chk("sim_t2", t2 - base, 8);
    chk("sim_t3", t3 - base, 9);
`ifdef GWA_INCNT_EN
    chk("sim_credit", int'(CREDIT), 6);
`endif

    // Long key hold gives one pulse; a second press gives another.
    clr();
    WT_RAW = 1'b1; tick(30);
    WT_RAW = 1'b0; tick(10);
    chk("hold_wt_cnt", c3, 1);
    WT_RAW = 1'b1; tick(10);
    WT_RAW = 1'b0; tick(15);
    chk("repeat_wt_cnt", c3, 2);

    // Reset asserted during the EU1 pulse discards the pending EU2.
    clr();
    EU1_RAW = 1'b1; EU2_RAW = 1'b1;
    tick(7);
    chk("midrst_eu1", int'(EU1), 1);
    rst = 1'b0;
    tick(2);
    chk("midrst_eu2", int'(EU2), 0);
    rst = 1'b1;
    tick(20);
    EU1_RAW = 1'b0; EU2_RAW = 1'b0;
    tick(20);
    chk("midrst_eu2_cnt", c2, 0);
    chk("midrst_eu1_cnt", c1, 1);
`ifdef GWA_INCNT_EN
    chk("midrst_credit", int'(CREDIT), 0);
`endif

    chk("one_hot", multi, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
